lsu_dccm_arb: RTL and testbench



---
 rtl/lsu_dccm_arb_pkg.sv | 12 +
 rtl/lsu_dccm_arb_starve_cnt.sv | 41 ++++
 rtl/lsu_dccm_arb.sv | 153 +++++++++++++++
 tb/tb_lsu_dccm_arb.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_dccm_arb_pkg.sv
// Shared types for the LSU DCCM slot arbiter: FSM state encoding and starvation counter width.
package lsu_dccm_arb_pkg;

    localparam int ARB_CNT_W = 8;

    typedef enum logic [1:0] {
        ARB_NORMAL      = 2'd0,
        ARB_DMA_FORCE   = 2'd1,
        ARB_STBUF_FORCE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/lsu_dccm_arb_starve_cnt.sv
// Saturating starvation counter: counts consecutive denied cycles; hit_o flags the MAX value.
module lsu_dccm_arb_starve_cnt
    import lsu_dccm_arb_pkg::*;
#(
    parameter int unsigned MAX = 8
) (
    input  logic clk,
    input  logic rst_l,
    input  logic inc_i,
    input  logic clr_i,
    input  logic hold_i,
    output logic hit_o
);

    localparam logic [ARB_CNT_W-1:0] MAX_C = ARB_CNT_W'(MAX);

    logic [ARB_CNT_W-1:0] cnt_q;
    logic [ARB_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (hold_i) begin
            cnt_d = cnt_q;
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == MAX_C);

endmodule

// File: rtl/lsu_dccm_arb.sv
// DCCM slot arbiter between LSU dc2 loads, store-buffer drain and DMA, with starvation forcing.
// Optional perf outputs are built when LSU_DCCM_ARB_PERF_EN is defined.
//
//   state           | meaning
//   ----------------+--------------------------------------------------
//   ARB_NORMAL      | priority lsu > stbuf > dma
//   ARB_DMA_FORCE   | decode stalled, priority lsu > dma > stbuf
//   ARB_STBUF_FORCE | decode stalled, priority lsu > stbuf > dma
module lsu_dccm_arb
    import lsu_dccm_arb_pkg::*;
#(
    parameter int unsigned DMA_STARVE_MAX   = 8,
    parameter int unsigned STBUF_STARVE_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       lsu_ld_req_dc2,
    input  logic       stbuf_req,
    input  logic       stbuf_full,
    input  logic       dma_req,
    input  logic       dma_write,
    input  logic       lsu_freeze_dc3,
    output logic       gnt_lsu,
    output logic       gnt_stbuf,
    output logic       gnt_dma,
    output logic       stall_decode,
    output logic [1:0] arb_state
`ifdef LSU_DCCM_ARB_PERF_EN
    ,
    output logic        perf_conflict,
    output logic        perf_force,
    output logic [15:0] perf_dma_wr_wait
`endif
);

    arb_state_t state_q, state_d;
    logic       stall_q, stall_d;
    logic       rst_done_q;
    logic       active;
    logic       dma_hit, stbuf_hit;
    logic       stbuf_blocked;

    // The first cycle out of reset and frozen cycles neither grant nor count as denials.
    assign active = rst_done_q & ~lsu_freeze_dc3;

    always_comb begin
        gnt_lsu   = active & lsu_ld_req_dc2;
        gnt_stbuf = 1'b0;
        gnt_dma   = 1'b0;
        if (active && !lsu_ld_req_dc2) begin
            if (state_q == ARB_DMA_FORCE) begin
                gnt_dma   = dma_req;
                gnt_stbuf = stbuf_req & ~dma_req;
            end else begin
                gnt_stbuf = stbuf_req;
                gnt_dma   = dma_req & ~stbuf_req;
            end
        end
    end

    lsu_dccm_arb_starve_cnt #(.MAX(DMA_STARVE_MAX)) u_dma_cnt (
        .clk    (clk),
        .rst_l  (rst_l),
        .inc_i  (dma_req & ~gnt_dma),
        .clr_i  (~dma_req | gnt_dma),
        .hold_i (~active),
        .hit_o  (dma_hit)
    );

    lsu_dccm_arb_starve_cnt #(.MAX(STBUF_STARVE_MAX)) u_stbuf_cnt (
        .clk    (clk),
        .rst_l  (rst_l),
        .inc_i  (stbuf_req & ~gnt_stbuf),
        .clr_i  (~stbuf_req | gnt_stbuf),
        .hold_i (~active),
        .hit_o  (stbuf_hit)
    );

    assign stbuf_blocked = stbuf_full & stbuf_req & ~gnt_stbuf;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_NORMAL: begin
                if (active) begin
                    if (dma_hit) begin
                        state_d = ARB_DMA_FORCE;
                    end else if (stbuf_hit || stbuf_blocked) begin
                        state_d = ARB_STBUF_FORCE;
                    end
                end
            end
            ARB_DMA_FORCE: begin
                // A starved store buffer that waited out the DMA force goes straight to its own.
                if (active && (gnt_dma || !dma_req)) begin
                    state_d = stbuf_hit ? ARB_STBUF_FORCE : ARB_NORMAL;
                end
            end
            ARB_STBUF_FORCE: begin
                if (active && ((gnt_stbuf && !stbuf_full) || !stbuf_req)) begin
                    state_d = ARB_NORMAL;
                end
            end
            default: state_d = ARB_NORMAL;
        endcase
    end

    assign stall_d = (state_d != ARB_NORMAL);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= ARB_NORMAL;
            stall_q    <= 1'b0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            rst_done_q <= 1'b1;
        end
    end

    assign stall_decode = stall_q;
    assign arb_state    = state_q;

`ifdef LSU_DCCM_ARB_PERF_EN
    logic        perf_force_q;
    logic [15:0] perf_wr_wait_q;

    assign perf_conflict = ~lsu_freeze_dc3 &
                           ((lsu_ld_req_dc2 & stbuf_req) |
                            (lsu_ld_req_dc2 & dma_req) |
                            (stbuf_req & dma_req));

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            perf_force_q   <= 1'b0;
            perf_wr_wait_q <= '0;
        end else begin
            perf_force_q <= (state_d != ARB_NORMAL) && (state_d != state_q);
            if (active && dma_req && dma_write && !gnt_dma && !(&perf_wr_wait_q)) begin
                perf_wr_wait_q <= perf_wr_wait_q + 16'd1;
            end
        end
    end

    assign perf_force       = perf_force_q;
    assign perf_dma_wr_wait = perf_wr_wait_q;
`else
    logic dma_write_unused;
    assign dma_write_unused = dma_write;
`endif

endmodule

// File: tb/tb_lsu_dccm_arb.sv
// Self-checking bench for lsu_dccm_arb: behavioural priority-list model plus directed literal checks.
module tb_lsu_dccm_arb;

    localparam int DMA_MAX = 8;
    localparam int ST_MAX  = 16;

    logic       clk;
    logic       rst_l;
    logic       lsu_ld_req_dc2, stbuf_req, stbuf_full, dma_req, dma_write, lsu_freeze_dc3;
    logic       gnt_lsu, gnt_stbuf, gnt_dma, stall_decode;
    logic [1:0] arb_state;
`ifdef LSU_DCCM_ARB_PERF_EN
    logic        perf_conflict, perf_force;
    logic [15:0] perf_dma_wr_wait;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    lsu_dccm_arb #(.DMA_STARVE_MAX(DMA_MAX), .STBUF_STARVE_MAX(ST_MAX)) dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .lsu_ld_req_dc2 (lsu_ld_req_dc2),
        .stbuf_req      (stbuf_req),
        .stbuf_full     (stbuf_full),
        .dma_req        (dma_req),
        .dma_write      (dma_write),
        .lsu_freeze_dc3 (lsu_freeze_dc3),
        .gnt_lsu        (gnt_lsu),
        .gnt_stbuf      (gnt_stbuf),
        .gnt_dma        (gnt_dma),
        .stall_decode   (stall_decode),
        .arb_state      (arb_state)
`ifdef LSU_DCCM_ARB_PERF_EN
        ,
        .perf_conflict    (perf_conflict),
        .perf_force       (perf_force),
        .perf_dma_wr_wait (perf_dma_wr_wait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // requester ids: 0 = lsu, 1 = stbuf, 2 = dma ; states: 0 normal, 1 dma force, 2 stbuf force
    int m_state = 0;
    int m_dcnt  = 0;
    int m_scnt  = 0;
    bit m_stall = 0;
    bit m_done  = 0;

    function automatic void model_gnts(output logic gl, output logic gs, output logic gd);
        int   order [3];
        logic req   [3];
        int   win;
        req[0] = lsu_ld_req_dc2;
        req[1] = stbuf_req;
        req[2] = dma_req;
        if (m_state == 1) begin
            order[0] = 0; order[1] = 2; order[2] = 1;
        end else begin
            order[0] = 0; order[1] = 1; order[2] = 2;
        end
        win = -1;
        if (rst_l && m_done && !lsu_freeze_dc3) begin
            for (int k = 0; k < 3; k++) begin
                if (req[order[k]] && win < 0) win = order[k];
            end
        end
        gl = (win == 0);
        gs = (win == 1);
        gd = (win == 2);
    endfunction

    logic mg_l, mg_s, mg_d;
    int   m_ns;

    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            m_state = 0; m_dcnt = 0; m_scnt = 0; m_stall = 0; m_done = 0;
        end else begin
            model_gnts(mg_l, mg_s, mg_d);
            if (m_done && !lsu_freeze_dc3) begin
                m_ns = m_state;
                if (m_state == 0) begin
                    if (m_dcnt == DMA_MAX) m_ns = 1;
                    else if (m_scnt == ST_MAX || (stbuf_full && stbuf_req && !mg_s)) m_ns = 2;
                end else if (m_state == 1) begin
                    if (mg_d || !dma_req) m_ns = (m_scnt == ST_MAX) ? 2 : 0;
                end else begin
                    if ((mg_s && !stbuf_full) || !stbuf_req) m_ns = 0;
                end
                m_dcnt  = (dma_req && !mg_d) ? ((m_dcnt < DMA_MAX) ? m_dcnt + 1 : m_dcnt) : 0;
                m_scnt  = (stbuf_req && !mg_s) ? ((m_scnt < ST_MAX) ? m_scnt + 1 : m_scnt) : 0;
                m_state = m_ns;
                m_stall = (m_ns != 0);
            end
            m_done = 1;
        end
    end

    logic eg_l, eg_s, eg_d;
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            model_gnts(eg_l, eg_s, eg_d);
            chk("m_gnt_lsu", gnt_lsu, eg_l);
            chk("m_gnt_stbuf", gnt_stbuf, eg_s);
            chk("m_gnt_dma", gnt_dma, eg_d);
            chk("m_arb_state", arb_state, m_state);
            chk("m_stall", stall_decode, m_stall);
            chk("m_onehot", $countones({gnt_lsu, gnt_stbuf, gnt_dma}) <= 1, 1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input logic l, input logic s, input logic f, input logic d, input logic z);
        lsu_ld_req_dc2 = l; stbuf_req = s; stbuf_full = f; dma_req = d; lsu_freeze_dc3 = z;
    endtask

    // Leaves the bench 3 time units into the first post-release cycle (C0).
    task automatic do_reset(input logic l, input logic s, input logic f, input logic d);
        @(negedge clk);
        rst_l = 1'b0;
        set_in(l, s, f, d, 1'b0);
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        #3;
    endtask

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    initial begin
        rst_l = 1'b0;
        dma_write = 1'b0;
        set_in(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk_en = 1;

        // reset release with all requests high
        do_reset(1, 1, 0, 1);
        chk("rel_c0_gnts", {gnt_lsu, gnt_stbuf, gnt_dma}, 3'b000);
        chk("rel_c0_state", arb_state, 0);
        step();
        chk("rel_c1_gnts", {gnt_lsu, gnt_stbuf, gnt_dma}, 3'b100);
        chk("rel_c1_stall", stall_decode, 0);
        chk("rel_c1_state", arb_state, 0);

        // DMA starvation behind a busy LSU
        do_reset(1, 0, 0, 1);
        repeat (9) step();
        chk("dma_c9_state", arb_state, 0);
        step();
        chk("dma_c10_state", arb_state, 1);
        chk("dma_c10_stall", stall_decode, 1);
        chk("dma_c10_gnts", {gnt_lsu, gnt_stbuf, gnt_dma}, 3'b100);
        @(negedge clk); lsu_ld_req_dc2 = 0; #3;
        chk("dma_c11_gnt", {gnt_lsu, gnt_stbuf, gnt_dma}, 3'b001);
        step();
        chk("dma_c12_state", arb_state, 0);
        chk("dma_c12_stall", stall_decode, 0);

        // store buffer full and blocked by a load
        do_reset(1, 1, 1, 0);
        step();
        chk("stf_c1_state", arb_state, 0);
        step();
        chk("stf_c2_state", arb_state, 2);
        chk("stf_c2_stall", stall_decode, 1);
        @(negedge clk); lsu_ld_req_dc2 = 0; #3;
        chk("stf_c3_gnt", {gnt_lsu, gnt_stbuf, gnt_dma}, 3'b010);
        @(negedge clk); stbuf_full = 0; #3;
        chk("stf_c4_state", arb_state, 2);
        chk("stf_c4_gnt", gnt_stbuf, 1);
        step();
        chk("stf_c5_state", arb_state, 0);
        chk("stf_c5_stall", stall_decode, 0);

        // both counters saturate together
        do_reset(1, 1, 0, 0);
        repeat (8) step();
        @(negedge clk); dma_req = 1; #3;
        repeat (8) step();
        chk("both_c17_state", arb_state, 0);
        step();
        chk("both_c18_state", arb_state, 1);
        @(negedge clk); lsu_ld_req_dc2 = 0; #3;
        chk("both_c19_gnt", {gnt_lsu, gnt_stbuf, gnt_dma}, 3'b001);
        step();
        chk("both_c20_state", arb_state, 2);
        chk("both_c20_gnt", {gnt_lsu, gnt_stbuf, gnt_dma}, 3'b010);
        step();
        chk("both_c21_state", arb_state, 0);

        // freeze while DMA has been denied 6 times
        do_reset(1, 0, 0, 1);
        repeat (6) step();
        @(negedge clk); lsu_freeze_dc3 = 1; #3;
        chk("frz_c7_gnts", {gnt_lsu, gnt_stbuf, gnt_dma}, 3'b000);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("frz_gnts", {gnt_lsu, gnt_stbuf, gnt_dma}, 3'b000);
        end
        @(negedge clk); lsu_freeze_dc3 = 0; #3;
        chk("frz_c12_gnts", {gnt_lsu, gnt_stbuf, gnt_dma}, 3'b100);
        step();
        step();
        chk("frz_c14_state", arb_state, 0);
        step();
        chk("frz_c15_state", arb_state, 1);

        // reset mid DMA force, with the LSU just gone idle
        @(negedge clk);
        rst_l = 1'b0;
        lsu_ld_req_dc2 = 0;
        #1;
        chk("rst_mid_state", arb_state, 0);
        chk("rst_mid_stall", stall_decode, 0);
        chk("rst_mid_gnts", {gnt_lsu, gnt_stbuf, gnt_dma}, 3'b000);
        @(negedge clk); rst_l = 1'b1; #3;
        chk("rst_rel_gnts", {gnt_lsu, gnt_stbuf, gnt_dma}, 3'b000);
        step();
        chk("rst_rel_c1_gnt", {gnt_lsu, gnt_stbuf, gnt_dma}, 3'b001);
        chk("rst_rel_c1_state", arb_state, 0);

        // randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (rst_l == 1'b0) begin
                rst_l = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                rst_l = 1'b0;
            end
            lsu_ld_req_dc2 = ($urandom_range(0, 99) < 65);
            stbuf_req      = ($urandom_range(0, 99) < 55);
            stbuf_full     = ($urandom_range(0, 99) < 15);
            dma_req        = ($urandom_range(0, 99) < 60);
            dma_write      = 1'($urandom_range(0, 1));
            lsu_freeze_dc3 = ($urandom_range(0, 99) < 8);
        end
        @(negedge clk);
        rst_l = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
